// File: rtl/nor_bist_pkg.sv
// Shared encodings for the NOR unit self-test engine.
package nor_bist_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        DONE = ST_DONE
    } state_t;

    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/nor_vec_counter.sv
// Operand-pair generator: op2 is the inner counter, op1 advances when op2 wraps.
module nor_vec_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic             last
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op1 <= '0;
            op2 <= '0;
        end else if (clr) begin
            op1 <= '0;
            op2 <= '0;
        end else if (inc) begin
            op2 <= op2 + 1'b1;
            if (&op2) op1 <= op1 + 1'b1;
        end
    end

    assign last = &{op1, op2};

endmodule

// File: rtl/nor_bist_engine.sv
// Exhaustive sweep of a WIDTH-bit NOR unit with settle delay, error count and first-fail capture.
module nor_bist_engine
    import nor_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 2*WIDTH + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    output logic [WIDTH-1:0]   o_op1,
    output logic [WIDTH-1:0]   o_op2,
    input  logic [WIDTH-1:0]   i_res,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic               o_err_flag,
    output logic [3*WIDTH-1:0] o_first_err
);

    localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE);

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                cmp_edge;
    logic                vc_clr;
    logic                vc_inc;
    logic                last;
    logic                mismatch;

    // Abort outranks both the start edge and the compare edge.
    assign cmp_edge = (state == WAIT) && !i_abort && (settle_cnt == '0);
    assign vc_clr   = (state != WAIT) && i_start && !i_abort;
    assign vc_inc   = cmp_edge && !last;
    assign mismatch = i_res != ~(o_op1 | o_op2);

    nor_vec_counter #(.WIDTH(WIDTH)) u_vec (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (vc_clr),
        .inc     (vc_inc),
        .op1     (o_op1),
        .op2     (o_op2),
        .last    (last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            o_err_cnt   <= '0;
            o_err_flag  <= 1'b0;
            o_first_err <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_abort) begin
                        state <= IDLE;
                    end else if (i_start) begin
                        state       <= WAIT;
                        settle_cnt  <= SETTLE_L;
                        o_err_cnt   <= '0;
                        o_err_flag  <= 1'b0;
                        o_first_err <= '0;
                    end
                end
                WAIT: begin
                    if (i_abort) begin
                        state <= IDLE;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else begin
                        if (mismatch) begin
                            o_err_cnt <= o_err_cnt + 1'b1;
                            if (!o_err_flag) begin
                                o_err_flag  <= 1'b1;
                                o_first_err <= {o_op1, o_op2, i_res};
                            end
                        end
                        settle_cnt <= SETTLE_L;
                        if (last) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state == WAIT);
    assign o_done = (state == DONE);

endmodule

// File: tb/tb_nor_bist_engine.sv
// Directed bench: two engines (SETTLE=1 and SETTLE=3) against ideal, stuck-at and delayed NOR models.
module tb_nor_bist_engine;

    typedef struct {
        int          cycles;
        logic [8:0]  cnt;
        logic        flag;
        logic [11:0] first;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;
    int   n;

    logic clk = 0, rst_n = 0, abort = 0, start1 = 0, start3 = 0;
    logic [3:0]  op1_1, op2_1, res_1, op1_3, op2_3, res_3;
    logic [3:0]  dl1_a, dl1_b, dl3_a, dl3_b;
    logic        busy1, done1, flag1, busy3, done3, flag3;
    logic [8:0]  cnt1, cnt3;
    logic [11:0] first1, first3;

    always #5 clk = ~clk;

    // Two-stage registered NOR used as the slow unit.
    always @(posedge clk) begin
        dl1_a <= ~(op1_1 | op2_1);
        dl1_b <= dl1_a;
        dl3_a <= ~(op1_3 | op2_3);
        dl3_b <= dl3_a;
    end

    function automatic logic [3:0] unit(input int m, input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] dly);
        case (m)
            1:       return ~(a | b) & 4'hB;
            2:       return dly;
            default: return ~(a | b);
        endcase
    endfunction

    assign res_1 = unit(mode, op1_1, op2_1, dl1_b);
    assign res_3 = unit(mode, op1_3, op2_3, dl3_b);

    nor_bist_engine #(.WIDTH(4), .SETTLE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort),
        .o_op1(op1_1), .o_op2(op2_1), .i_res(res_1), .o_busy(busy1), .o_done(done1),
        .o_err_cnt(cnt1), .o_err_flag(flag1), .o_first_err(first1)
    );

    nor_bist_engine #(.WIDTH(4), .SETTLE(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_abort(abort),
        .o_op1(op1_3), .o_op2(op2_3), .i_res(res_3), .o_busy(busy3), .o_done(done3),
        .o_err_cnt(cnt3), .o_err_flag(flag3), .o_first_err(first3)
    );

    // Expected sweep outcome for an ideal (m=0) or bit-2 stuck-at-0 (m=1) unit.
    function automatic exp_t model(input int m, input int settle);
        exp_t e;
        e.cycles = 256 * (settle + 1);
        e.cnt    = '0;
        e.flag   = 1'b0;
        e.first  = '0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] r, o;
                r = ~(4'(a) | 4'(b));
                o = (m == 1) ? (r & 4'hB) : r;
                if (o != r) begin
                    e.cnt++;
                    if (!e.flag) begin
                        e.flag  = 1'b1;
                        e.first = {4'(a), 4'(b), o};
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input bit sel);
        @(negedge clk);
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic sweep(input bit sel, input int pulse_at, output int cyc);
        cyc = 0;
        while (!(sel ? done3 : done1) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!sel) start1 = (cyc == pulse_at);
        end
        start1 = 1'b0;
    endtask

    task automatic check_sb(input bit sel, input int cyc);
        exp_t e;
        chk("sb_size", sb.size(), 1);
        e = sb.pop_front();
        chk("sweep_cycles", cyc, e.cycles);
        chk("err_cnt",   sel ? cnt3 : cnt1,     e.cnt);
        chk("err_flag",  sel ? flag3 : flag1,   e.flag);
        chk("first_err", sel ? first3 : first1, e.first);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ops",   {op1_1, op2_1}, 0);
        chk("rst_cnt",   cnt1, 0);
        chk("rst_flag",  flag1, 0);
        chk("rst_first", first1, 0);
        chk("rst_busy",  busy1, 0);
        chk("rst_done",  done1, 0);
        rst_n = 1'b1;

        // Clean sweep
        mode = 0;
        sb.push_back(model(0, 1));
        kick(0);
        chk("start_ops", {op1_1, op2_1}, 0);
        chk("start_busy", busy1, 1);
        sweep(0, -1, n);
        check_sb(0, n);
        chk("done_ops", {op1_1, op2_1}, 8'hFF);
        chk("done_busy", busy1, 0);

        // Stuck-at-0 on res[2], restarted from DONE
        mode = 1;
        sb.push_back(model(1, 1));
        kick(0);
        sweep(0, -1, n);
        chk("stuck_cnt_64", cnt1, 64);
        chk("stuck_first", first1, 12'h00B);
        check_sb(0, n);

        // start and abort together in DONE: abort wins, results kept
        @(negedge clk);
        start1 = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort  = 1'b0;
        chk("sa_done", done1, 0);
        chk("sa_busy", busy1, 0);
        chk("sa_cnt_kept", cnt1, 64);

        // Restart clears counters; a start mid-WAIT is ignored
        mode = 0;
        sb.push_back(model(0, 1));
        kick(0);
        chk("restart_cnt", cnt1, 0);
        chk("restart_flag", flag1, 0);
        chk("restart_first", first1, 0);
        sweep(0, 50, n);
        check_sb(0, n);

        // Abort after 100 cycles
        kick(0);
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ops", {op1_1, op2_1}, 8'h32);
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        repeat (5) @(negedge clk);
        chk("abort_frozen", {op1_1, op2_1}, 8'h32);
        sb.push_back(model(0, 1));
        kick(0);
        chk("reabort_ops", {op1_1, op2_1}, 0);
        sweep(0, -1, n);
        check_sb(0, n);

        // Asynchronous reset mid-sweep
        mode = 1;
        kick(0);
        repeat (37) @(negedge clk);
        chk("pre_rst_busy", busy1, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ops",   {op1_1, op2_1}, 0);
        chk("arst_cnt",   cnt1, 0);
        chk("arst_flag",  flag1, 0);
        chk("arst_first", first1, 0);
        chk("arst_busy",  busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        sb.push_back(model(0, 1));
        kick(0);
        sweep(0, -1, n);
        check_sb(0, n);

        // Slow unit: enough settle time on dut3, too little on dut1
        mode = 2;
        sb.push_back(model(0, 3));
        kick(1);
        sweep(1, -1, n);
        check_sb(1, n);
        kick(0);
        sweep(0, -1, n);
        chk("dly_cycles", n, 512);
        chk("dly_errs_nonzero", cnt1 != 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
